// File: rtl/imem_loader.sv
// imem_loader: boot-time instruction-memory loader.
// Receives a framed byte stream (16-bit LE word count, 4*N payload bytes,
// XOR checksum byte). Assembles little-endian 32-bit words and writes them
// sequentially through a synchronous imem write port. Holds the core in
// reset until a complete, checksum-verified image is in place.
module imem_loader #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam logic [15:0] DEPTH16 = 16'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CNT_LO,
    S_CNT_HI,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  // Status outputs that are a pure function of the FSM state.
  typedef struct packed {
    logic rx_ready;
    logic busy;
    logic done;
    logic error;
    logic cpu_reset;
  } flags_t;

  function automatic flags_t flags_of(input state_t s);
    flags_t f;
    f = '{rx_ready: 1'b0, busy: 1'b0, done: 1'b0, error: 1'b0, cpu_reset: 1'b1};
    case (s)
      S_CNT_LO, S_CNT_HI, S_DATA, S_CSUM: begin
        f.rx_ready = 1'b1;
        f.busy     = 1'b1;
      end
      S_DONE: begin
        f.done      = 1'b1;
        f.cpu_reset = 1'b0;
      end
      S_ERR:   f.error = 1'b1;
      default: ;
    endcase
    return f;
  endfunction

  state_t              state;
  flags_t              flags;
  logic [15:0]         count;     // word count N from the header
  logic [ADDR_W-1:0]   word_idx;  // address of the word being assembled
  logic [1:0]          byte_idx;  // lane of the next payload byte
  logic [7:0]          csum;      // running XOR of payload bytes
  logic [23:0]         asm_lo;    // lanes 0..2 of the word being assembled

  logic                xfer;
  logic [15:0]         hdr_n;
  logic [15:0]         word_idx_ext;
  logic                last_word;

  assign xfer         = rx_valid & flags.rx_ready;
  assign hdr_n        = {rx_data, count[7:0]};
  assign word_idx_ext = {{(16-ADDR_W){1'b0}}, word_idx};
  assign last_word    = (word_idx_ext == count - 16'd1);

  assign rx_ready  = flags.rx_ready;
  assign busy      = flags.busy;
  assign done      = flags.done;
  assign error     = flags.error;
  assign cpu_reset = flags.cpu_reset;

  // Loader FSM: consumes the frame, assembles words, drives the imem write
  // port and the status outputs.
  // NOTE: the status flags are loaded from the *destination* state at the
  // same edge the state changes, so they are registered yet never lag state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      flags      <= flags_of(S_IDLE);
      count      <= '0;
      word_idx   <= '0;
      byte_idx   <= '0;
      csum       <= '0;
      asm_lo     <= '0;
      imem_we    <= 1'b0;
      imem_waddr <= '0;
      imem_wdata <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout; this default is overridden
      // later in the block on a word-completing transfer, giving a 1-cycle pulse.
      imem_we <= 1'b0;
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            state <= S_CNT_LO;
            flags <= flags_of(S_CNT_LO);
          end
        end
        S_CNT_LO: begin
          if (xfer) begin
            count[7:0] <= rx_data;
            state      <= S_CNT_HI;
            flags      <= flags_of(S_CNT_HI);
          end
        end
        S_CNT_HI: begin
          if (xfer) begin
            count[15:8] <= rx_data;
            if (hdr_n == 16'd0 || hdr_n > DEPTH16) begin
              state <= S_ERR;
              flags <= flags_of(S_ERR);
            end else begin
              word_idx <= '0;
              byte_idx <= '0;
              csum     <= '0;
              state    <= S_DATA;
              flags    <= flags_of(S_DATA);
            end
          end
        end
        S_DATA: begin
          if (xfer) begin
            csum     <= csum ^ rx_data;
            byte_idx <= byte_idx + 2'd1;
            case (byte_idx)
              2'd0: asm_lo[7:0]   <= rx_data;
              2'd1: asm_lo[15:8]  <= rx_data;
              2'd2: asm_lo[23:16] <= rx_data;
              2'd3: begin
                imem_wdata <= {rx_data, asm_lo};
                imem_waddr <= word_idx;
                imem_we    <= 1'b1;
                word_idx   <= word_idx + ADDR_W'(1);
                if (last_word) begin
                  state <= S_CSUM;
                  flags <= flags_of(S_CSUM);
                end
              end
              default: ;
            endcase
          end
        end
        S_CSUM: begin
          if (xfer) begin
            if (rx_data == csum) begin
              state <= S_DONE;
              flags <= flags_of(S_DONE);
            end else begin
              state <= S_ERR;
              flags <= flags_of(S_ERR);
            end
          end
        end
        default: begin
          state <= S_IDLE;
          flags <= flags_of(S_IDLE);
        end
      endcase
    end
  end

endmodule
